axis_rr_arbiter_mux: RTL
========================

# axis_rr_arbiter_mux

Round-robin arbiter and multiplexer that shares one AXI-Stream master port between `N_SRC` AXI-Stream slave ports. It sits between the stream producers and the single downstream stream consumer. It extends the two-requester round-robin arbiter to full stream handshakes with packet-boundary grant locking. The grant is registered; the data path is a combinational mux of the granted source.

## Interface
- `N_SRC`, 4, number of source streams (2..16)
- `DATA_W`, 8, tdata width in bits
- `ID_W`, $clog2(N_SRC), width of source index

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `s_axis_tdata`  in  N_SRC*DATA_W  source data; source i occupies bits [i*DATA_W +: DATA_W]
- `s_axis_tvalid`  in  N_SRC  per-source valid
- `s_axis_tlast`  in  N_SRC  per-source end-of-packet
- `s_axis_tready`  out  N_SRC  per-source ready
- `m_axis_tdata`  out  DATA_W  granted source data
- `m_axis_tvalid`  out  1  granted source valid
- `m_axis_tlast`  out  1  granted source tlast
- `m_axis_tid`  out  ID_W  index of granted source
- `m_axis_tready`  in  1  downstream ready

## Operation
- FSM has two states, IDLE and GRANT; a `grant` register holds an ID_W value; a `last` register holds an ID_W value.
- Reset values:
  - state is IDLE.
  - `grant` is 0; `last` is N_SRC-1, so source 0 has first priority.
  - `m_axis_tvalid` is 0; `m_axis_tlast` is 0; `m_axis_tid` is 0; `m_axis_tdata` is 0.
  - `s_axis_tready` is all 0.
- IDLE:
  - All `s_axis_tready` are 0 and `m_axis_tvalid` is 0.
  - If any `s_axis_tvalid` is 1, select the first valid source scanning `last+1, last+2, …` modulo N_SRC.
  - Load that source into `grant` and go to GRANT.
- GRANT:
  - `m_axis_tdata`, `m_axis_tvalid` and `m_axis_tlast` equal the fields of source `grant`.
  - `m_axis_tid` equals `grant`.
  - `s_axis_tready[grant]` equals `m_axis_tready`; all other `s_axis_tready` bits are 0.
- End of grant:
  - Condition: a beat transfers (`m_axis_tvalid && m_axis_tready`) and that beat ends the grant (see Configuration).
  - Action: `last` takes `grant` and the state returns to IDLE.
- Source `grant` dropping tvalid mid-packet does not release the grant. The bus stays owned and `m_axis_tvalid` is 0.
- No beat is ever dropped, duplicated or reordered within a source.
- `rst` asserted in any state forces the reset values on the next edge. A partial packet is abandoned and the source must resend it.

## Timing
- Arbitration latency is 1 cycle. A source first valid in IDLE in cycle k produces `m_axis_tvalid`=1 in cycle k+1.
- Throughput in GRANT is 1 beat/cycle when the source and sink are both ready.
- There is one IDLE bubble cycle between consecutive grants.
- Ready and valid pass combinationally through the mux; there is no internal buffering.
- Under `m_axis_tready`=0 the outputs hold stable because the source holds per AXI-Stream rules.
- Under continuous demand from all sources, no source waits more than N_SRC grants.

## Configuration
- `AXIS_ARB_PKT_LOCK_EN` defined:
  - A grant ends only on a transferred beat with `tlast`=1.
  - Packets from different sources are never interleaved.
- `AXIS_ARB_PKT_LOCK_EN` not defined:
  - Every transferred beat ends the grant, so arbitration happens per beat.
  - `m_axis_tid` must be used downstream to demultiplex.

## Test plan
- **Reset:**
  - Stimulus: `rst`=1 for 5 cycles with all `s_axis_tvalid`=1.
  - Required: `m_axis_tvalid`=0, `s_axis_tready`=0000 and `m_axis_tid`=0 throughout.
  - First grant after release goes to source 0.
- **Single source:**
  - Stimulus: source 1 sends 0xA1, 0xA2, 0xA3 (tlast on 0xA3) starting cycle k, with `m_axis_tready`=1.
  - Required: the master shows 0xA1/0xA2/0xA3 in cycles k+1..k+3 with `m_axis_tid`=1 and tlast on the third beat.
  - Required: the state is IDLE in cycle k+4.
- **Fairness:**
  - Stimulus: all four sources continuously valid with 1-beat packets and `m_axis_tready`=1.
  - Required: `m_axis_tid` sequence is 0,1,2,3,0,1 with one bubble between beats.
- **Packet lock:**
  - Stimulus: source 0 sends a 3-beat packet; source 2 becomes valid after beat 1.
  - Required with macro: source 2 is granted only after source 0's tlast beat.
  - Required without macro: tid sequence is 0,2,0,0.
- **Backpressure:**
  - Stimulus: `m_axis_tready`=0 for 3 cycles mid-packet.
  - Required: `s_axis_tready[grant]`=0, `m_axis_tdata` is unchanged, and no beat is lost or duplicated.
- **Reset mid-packet:**
  - Stimulus: assert `rst` after beat 2 of a 4-beat packet from source 3.
  - Required: next cycle `m_axis_tvalid`=0 and the state is IDLE.
  - Required: the next grant is to source 0 when sources 0 and 3 are both valid.

Source files
------------

// File: rtl/axis_rr_arbiter_mux.sv
// Round-robin arbiter and mux that shares one AXI-Stream master between N_SRC slave streams.
// Build option: define AXIS_ARB_PKT_LOCK_EN to hold each grant until a tlast beat transfers.

module axis_rr_arbiter_mux #(
   parameter int N_SRC  = 4,
   parameter int DATA_W = 8,
   parameter int ID_W   = $clog2(N_SRC)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_SRC*DATA_W-1:0] s_axis_tdata,
   input  logic [N_SRC-1:0]        s_axis_tvalid,
   input  logic [N_SRC-1:0]        s_axis_tlast,
   output logic [N_SRC-1:0]        s_axis_tready,
   output logic [DATA_W-1:0]       m_axis_tdata,
   output logic                    m_axis_tvalid,
   output logic                    m_axis_tlast,
   output logic [ID_W-1:0]         m_axis_tid,
   input  logic                    m_axis_tready
);

   // state | meaning
   // IDLE  | bus free; outputs quiet, pick next source after `last`
   // GRANT | bus owned by `grant`; handshakes routed through the mux

   typedef enum logic {IDLE, GRANT} state_t;

   state_t            state, state_nxt;
   logic [ID_W-1:0]   grant, grant_nxt;
   logic [ID_W-1:0]   last, last_nxt;
   logic [ID_W-1:0]   pick;
   logic [ID_W-1:0]   idx;
   logic              pick_ok;
   logic              xfer;
   logic              beat_end;
   logic [DATA_W-1:0] src_data [N_SRC];

   for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
      assign src_data[i] = s_axis_tdata[i*DATA_W +: DATA_W];
   end

   // First valid source at offsets 1..N_SRC after the previous owner.
   always_comb begin
      pick    = '0;
      pick_ok = 1'b0;
      idx     = '0;
      for (int off = 1; off <= N_SRC; off++) begin
         idx = ID_W'((int'(last) + off) % N_SRC);
         if (!pick_ok && s_axis_tvalid[idx]) begin
            pick    = idx;
            pick_ok = 1'b1;
         end
      end
   end

   always_comb begin
      m_axis_tdata  = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      m_axis_tid    = '0;
      s_axis_tready = '0;
      if (state == GRANT) begin
         m_axis_tdata         = src_data[grant];
         m_axis_tvalid        = s_axis_tvalid[grant];
         m_axis_tlast         = s_axis_tlast[grant];
         m_axis_tid           = grant;
         s_axis_tready[grant] = m_axis_tready;
      end
   end

   assign xfer = m_axis_tvalid && m_axis_tready;

`ifdef AXIS_ARB_PKT_LOCK_EN
   assign beat_end = xfer && m_axis_tlast;
`else
   assign beat_end = xfer;
`endif

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      last_nxt  = last;
      case (state)
         IDLE: begin
            if (pick_ok) begin
               grant_nxt = pick;
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            if (beat_end) begin
               last_nxt  = grant;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         grant <= '0;
         last  <= ID_W'(N_SRC - 1);
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
         last  <= last_nxt;
      end
   end

endmodule
